// File: rtl/zipo_fetch.sv
// zipo_fetch: 64-bit instruction prefetch feeding decode through a small FIFO.
// Define ZIPO_FETCH_STATS_EN to add the stat_fetched/stat_stall counters.
module zipo_fetch #(
    parameter logic [63:0] INITIAL_PC = 64'h0,
    parameter int unsigned DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
`ifdef ZIPO_FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_stall
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_F = DEPTH[CW:0];
    localparam logic [CW:0] TWO = {{(CW - 1){1'b0}}, 2'd2};

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state_q, state_d;
    logic [63:0]   fetch_pc, fetch_pc_d;
    logic          req_d;
    logic [63:0]   addr_d;
    logic [63:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, wr_nxt;
    logic [CW-1:0] count;
    logic          pop;
    logic [1:0]    n_push;
    logic [CW:0]   free;
    logic [63:0]   push_pc0, push_pc1;
    logic [31:0]   push_ins0, push_ins1;
    logic          unused_pc_lo;

    assign unused_pc_lo = ^redirect_pc[1:0];
    assign inst_valid   = (count != '0);
    assign inst         = ins_mem[rd_ptr];
    assign inst_pc      = pc_mem[rd_ptr];
    assign pop          = inst_valid & inst_ready;
    assign wr_nxt       = wr_ptr + AW'(1);
    // Room is judged after this cycle's pop so a draining FIFO refetches early.
    assign free = DEPTH_F - {1'b0, count} + {{CW{1'b0}}, pop};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc;
        req_d      = mem_req;
        addr_d     = mem_addr;
        n_push     = 2'd0;
        push_pc0   = fetch_pc;
        push_ins0  = mem_rdata[31:0];
        push_pc1   = fetch_pc + 64'd4;
        push_ins1  = mem_rdata[63:32];
        unique case (state_q)
            IDLE: begin
                if (!redirect_valid && free >= TWO) begin
                    req_d   = 1'b1;
                    addr_d  = {fetch_pc[63:3], 3'b000};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!redirect_valid) begin
                        if (fetch_pc[2]) begin
                            n_push    = 2'd1;
                            push_ins0 = mem_rdata[63:32];
                        end else begin
                            n_push = 2'd2;
                        end
                        fetch_pc_d = {fetch_pc[63:3] + 61'd1, 3'b000};
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) fetch_pc_d = {redirect_pc[63:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fetch_pc <= {INITIAL_PC[63:2], 2'b00};
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            fetch_pc <= fetch_pc_d;
            mem_req  <= req_d;
            mem_addr <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (n_push != 2'd0) begin
                pc_mem[wr_ptr]  <= push_pc0;
                ins_mem[wr_ptr] <= push_ins0;
            end
            if (n_push == 2'd2) begin
                pc_mem[wr_nxt]  <= push_pc1;
                ins_mem[wr_nxt] <= push_ins1;
            end
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

`ifdef ZIPO_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (pop && !redirect_valid) stat_fetched <= stat_fetched + 32'd1;
            if (inst_ready && !inst_valid) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule
